decoder_scan: RTL and testbench

DECODER_SCAN -- requirements
Module: decoder_scan

---
 rtl/decoder_pkg.sv | 13 +
 rtl/onehot_dec.sv | 14 +
 rtl/decoder_scan.sv | 119 +++++++++++
 tb/tb_decoder_scan.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared state enum and mode constants for the scanning decoder
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - combinational binary to one-hot decoder
module onehot_dec #(
    parameter int W = 3
) (
    input  logic [W-1:0]      code,
    output logic [2**W-1:0]   onehot
);

    always_comb begin
        onehot       = '0;
        onehot[code] = 1'b1;
    end

endmodule

// File: rtl/decoder_scan.sv
// rtl/decoder_scan.sv - registered one-hot decoder with direct and auto-scan modes
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int W       = 3,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       w,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2**W-1:0]    out,
    output logic               out_valid,
    output logic               busy,
    output logic               done
);

    state_t               state, state_n;
    logic [W-1:0]         code, code_n;
    logic [W-1:0]         start, start_n;
    logic [W-1:0]         code_inc;
    logic [W-1:0]         dec_sel;
    logic [DWELL_W-1:0]   cnt, cnt_n;
    logic [DWELL_W-1:0]   dwell_q, dwell_n;
    logic [2**W-1:0]      dec, out_n;
    logic                 done_n;
    logic                 accept;

    assign in_ready  = rst_n && en && (state != SCAN);
    assign accept    = in_valid && in_ready;
    assign code_inc  = W'(code + 1'b1);
    assign out_valid = |out;
    assign busy      = (state == SCAN);

    onehot_dec #(.W(W)) u_dec (
        .code   (dec_sel),
        .onehot (dec)
    );

    always_comb begin
        state_n = state;
        code_n  = code;
        start_n = start;
        cnt_n   = cnt;
        dwell_n = dwell_q;
        dec_sel = code;
        out_n   = out;
        done_n  = 1'b0;
        if (!en) begin
            state_n = IDLE;
            cnt_n   = '0;
            out_n   = '0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        code_n  = w;
                        dec_sel = w;
                        out_n   = dec;
                        if (mode == MODE_SCAN) begin
                            state_n = SCAN;
                            start_n = w;
                            dwell_n = dwell;
                            cnt_n   = '0;
                        end else begin
                            state_n = HOLD;
                        end
                    end
                end
                SCAN: begin
                    if (cnt == dwell_q) begin
                        cnt_n = '0;
                        // the scan has covered every code once it would wrap back to its start
                        if (code_inc == start) begin
                            state_n = IDLE;
                            out_n   = '0;
                            done_n  = 1'b1;
                        end else begin
                            code_n  = code_inc;
                            dec_sel = code_inc;
                            out_n   = dec;
                        end
                    end else begin
                        cnt_n = DWELL_W'(cnt + 1'b1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    out_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            code    <= '0;
            start   <= '0;
            cnt     <= '0;
            dwell_q <= '0;
            out     <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            code    <= code_n;
            start   <= start_n;
            cnt     <= cnt_n;
            dwell_q <= dwell_n;
            out     <= out_n;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_decoder_scan.sv
// tb/tb_decoder_scan.sv - scoreboard bench for decoder_scan at W=3 and W=4
module tb_decoder_scan;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       en3, mode3, valid3, ready3, ovalid3, busy3, done3;
    logic [2:0] w3;
    logic [7:0] dwell3;
    logic [7:0] out3;

    logic        en4, mode4, valid4, ready4, ovalid4, busy4, done4;
    logic [3:0]  w4;
    logic [1:0]  dwell4;
    logic [15:0] out4;

    int n_vec  = 0;
    int n_fail = 0;
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    decoder_scan #(.W(3), .DWELL_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .mode(mode3), .in_valid(valid3),
        .in_ready(ready3), .w(w3), .dwell(dwell3), .out(out3),
        .out_valid(ovalid3), .busy(busy3), .done(done3)
    );

    decoder_scan #(.W(4), .DWELL_W(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .mode(mode4), .in_valid(valid4),
        .in_ready(ready4), .w(w4), .dwell(dwell4), .out(out4),
        .out_valid(ovalid4), .busy(busy4), .done(done4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] mk(input int o, input bit v, input bit b, input bit d, input bit r);
        return {r, d, b, v, 16'(o)};
    endfunction

    function automatic logic [19:0] obs(input bit sel);
        if (sel) return {ready4, done4, busy4, ovalid4, out4};
        return {ready3, done3, busy3, ovalid3, 8'h00, out3};
    endfunction

    task automatic drive(input bit sel, input bit m, input int wv, input int dv);
        @(negedge clk);
        if (sel) begin
            valid4 = 1'b1; mode4 = m; w4 = 4'(wv); dwell4 = 2'(dv);
        end else begin
            valid3 = 1'b1; mode3 = m; w3 = 3'(wv); dwell3 = 8'(dv);
        end
        @(posedge clk);
    endtask

    task automatic drain(input bit sel, input bit hold, input string tag);
        logic [19:0] e, o;
        bit first;
        first = 1'b1;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = obs(sel);
            chk(tag, 32'(o), 32'(e));
            chk({tag, "_onehot"}, 32'($onehot0(o[15:0])), 32'd1);
            chk({tag, "_vld"}, 32'(o[16]), 32'(o[15:0] != 16'h0));
            if ((first && !hold) || exp_q.size() == 0) begin
                if (sel) valid4 = 1'b0; else valid3 = 1'b0;
            end
            first = 1'b0;
        end
    endtask

    task automatic push_scan(input int nw, input int w0, input int dw);
        int code;
        for (int k = 0; k < (1 << nw); k++) begin
            code = (w0 + k) % (1 << nw);
            for (int c = 0; c <= dw; c++) exp_q.push_back(mk(1 << code, 1, 1, 0, 0));
        end
        exp_q.push_back(mk(0, 0, 0, 1, 1));
    endtask

    initial begin
        rst_n = 1'b0;
        en3 = 1'b1; mode3 = 1'b0; valid3 = 1'b0; w3 = '0; dwell3 = '0;
        en4 = 1'b1; mode4 = 1'b0; valid4 = 1'b0; w4 = '0; dwell4 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset3", 32'(obs(0)), 32'(mk(0, 0, 0, 0, 0)));
        chk("reset4", 32'(obs(1)), 32'(mk(0, 0, 0, 0, 0)));
        rst_n = 1'b1;
        @(negedge clk);
        chk("release3", 32'(obs(0)), 32'(mk(0, 0, 0, 0, 1)));
        chk("release4", 32'(obs(1)), 32'(mk(0, 0, 0, 0, 1)));

        for (int i = 0; i < 8; i++) begin
            drive(0, 0, i, 0);
            exp_q.push_back(mk(1 << i, 1, 0, 0, 1));
            drain(0, 0, $sformatf("direct_w%0d", i));
        end
        w3 = 3'd2; mode3 = 1'b1; dwell3 = 8'd5;
        exp_q.push_back(mk(8'h80, 1, 0, 0, 1));
        exp_q.push_back(mk(8'h80, 1, 0, 0, 1));
        drain(0, 0, "hold_stable");

        drive(0, 1, 6, 1);
        push_scan(3, 6, 1);
        drain(0, 0, "scan_w6_d1");

        drive(0, 1, 0, 0);
        push_scan(3, 0, 0);
        drain(0, 1, "scan_w0_d0");
        exp_q.push_back(mk(0, 0, 0, 0, 1));
        drain(0, 0, "after_scan");

        drive(0, 1, 2, 3);
        for (int c = 0; c < 4; c++) exp_q.push_back(mk(8'h04, 1, 1, 0, 0));
        exp_q.push_back(mk(8'h08, 1, 1, 0, 0));
        drain(0, 0, "pre_abort");
        en3 = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        drain(0, 0, "abort");
        en3 = 1'b1;
        #1 chk("ready_after_en", 32'(ready3), 32'd1);

        drive(0, 0, 5, 0);
        exp_q.push_back(mk(8'h20, 1, 0, 0, 1));
        drain(0, 0, "pre_reset");
        rst_n = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        drain(0, 0, "in_reset");
        rst_n = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 1));
        drain(0, 0, "post_reset");
        drive(0, 0, 1, 0);
        exp_q.push_back(mk(8'h02, 1, 0, 0, 1));
        drain(0, 0, "direct_after_reset");

        drive(1, 1, 15, 3);
        push_scan(4, 15, 3);
        drain(1, 0, "scan4_w15_d3");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
